// File: rtl/center_stream_if.sv
// Stream bundle for center_stream: sample input, centred-sample output and
// the per-row mean / frame status sideband. The slave modport is the block's
// view; the master modport is the view of whatever drives and consumes it.
interface center_stream_if #(
  parameter int N_BITS = 22,
  parameter int ROW_W  = 3
);
  logic [N_BITS-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [N_BITS-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [ROW_W-1:0]  out_row;
  logic [N_BITS-1:0] mean;
  logic              mean_valid;
  logic              frame_done;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_row,
           mean, mean_valid, frame_done
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_row,
           mean, mean_valid, frame_done
  );
endinterface

// File: rtl/center_stream.sv
// center_stream: streaming per-row mean removal.
// Buffers one row of SIZE_B signed samples while summing it, computes the
// floor mean with an arithmetic shift, then replays the row minus the mean.
// Optional feature: define CENTER_STREAM_SAT_EN to clamp the centred sample
// to the N_BITS signed range; otherwise it wraps (two's complement).
module center_stream #(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int N_BITS = 22
) (
  input  logic           clk,
  input  logic           rst_n,
  center_stream_if.slave s
);
  localparam int LOG_B = $clog2(SIZE_B);
  localparam int ROW_W = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
  localparam int ACC_W = N_BITS + LOG_B;
  localparam logic [LOG_B-1:0] COL_LAST = LOG_B'(SIZE_B - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SIZE_A - 1);

  typedef enum logic [1:0] {ACCUM, MEAN, EMIT} state_t;

  state_t                         state;
  logic signed [ACC_W-1:0]        acc;
  logic [LOG_B-1:0]               col;
  logic [ROW_W-1:0]               row;
  logic [SIZE_B-1:0][N_BITS-1:0]  buffer;
  logic [N_BITS-1:0]              mean_q;
  logic                           in_ready_q;
  logic                           out_valid_q;
  logic                           mean_valid_q;
  logic                           frame_done_q;

  logic                           accept;
  logic                           xfer;
  logic signed [ACC_W-1:0]        row_sum;
  logic signed [ACC_W-1:0]        mean_full;
  logic signed [N_BITS:0]         diff;
  logic [N_BITS-1:0]              centred;

  assign accept    = s.in_valid && in_ready_q;
  assign xfer      = out_valid_q && s.out_ready;
  // Sum including the sample being accepted, so the last sample of the row
  // feeds the mean in the same cycle it is taken.
  assign row_sum   = acc + $signed({{LOG_B{s.in_data[N_BITS-1]}}, s.in_data});
  assign mean_full = row_sum >>> LOG_B;
  // One extra bit so buffer - mean can never overflow before reduction.
  assign diff      = $signed({buffer[col][N_BITS-1], buffer[col]})
                   - $signed({mean_q[N_BITS-1], mean_q});

  // Reduce the N_BITS+1 difference back to the sample width.
  always_comb begin
    centred = diff[N_BITS-1:0];
`ifdef CENTER_STREAM_SAT_EN
    if (diff[N_BITS] != diff[N_BITS-1])
      centred = diff[N_BITS] ? {1'b1, {(N_BITS-1){1'b0}}}
                             : {1'b0, {(N_BITS-1){1'b1}}};
`endif
  end

  assign s.in_ready   = in_ready_q;
  assign s.out_valid  = out_valid_q;
  assign s.out_data   = out_valid_q ? centred : '0;
  assign s.out_last   = out_valid_q && (col == COL_LAST);
  assign s.out_row    = row;
  assign s.mean       = mean_q;
  assign s.mean_valid = mean_valid_q;
  assign s.frame_done = frame_done_q;

  // Row FSM: accumulate/buffer, compute mean, replay centred row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      col          <= '0;
      row          <= '0;
      buffer       <= '0;
      mean_q       <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      mean_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      mean_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            buffer[col] <= s.in_data;
            acc         <= row_sum;
            col         <= col + 1'b1;
            if (col == COL_LAST) begin
              mean_q       <= mean_full[N_BITS-1:0];
              mean_valid_q <= 1'b1;
              in_ready_q   <= 1'b0;
              state        <= MEAN;
            end
          end
        end
        MEAN: begin
          acc         <= '0;
          col         <= '0;
          out_valid_q <= 1'b1;
          state       <= EMIT;
        end
        EMIT: begin
          if (xfer) begin
            col <= col + 1'b1;
            if (col == COL_LAST) begin
              out_valid_q  <= 1'b0;
              in_ready_q   <= 1'b1;
              row          <= (row == ROW_LAST) ? '0 : row + 1'b1;
              frame_done_q <= (row == ROW_LAST);
              state        <= ACCUM;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_center_stream.sv
// Randomised scoreboard bench for center_stream. The stimulus side computes
// each row's expected mean and centred outputs arithmetically and queues them;
// a monitor pops and compares on every output handshake and mean pulse.
module tb_center_stream;
  localparam int SA = 8;
  localparam int SB = 8;
  localparam int N  = 22;
  localparam int RW = 3;

  typedef struct {
    logic [N-1:0]  data;
    logic          last;
    logic [RW-1:0] row;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  center_stream_if #(.N_BITS(N), .ROW_W(RW)) ifc ();

  center_stream #(.SIZE_A(SA), .SIZE_B(SB), .N_BITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (ifc.slave)
  );

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int mode = 0;        // 0: ready held high, 1: random ready, 2: stall 3rd output
  bit period_chk = 1'b0;
  int exp_row = 0;
  longint row_buf[SB];
  exp_t exp_q[$];
  logic [N-1:0] mean_q[$];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Hand one sample over; called just after a falling edge.
  task automatic send(input logic [N-1:0] v);
    int g = 0;
    ifc.in_data  = v;
    ifc.in_valid = 1'b1;
    while (!ifc.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("in_ready_timeout", 1, 0);
    @(negedge clk);
  endtask

  // Reference: floor mean from the row sum, centred values, then stream row.
  task automatic run_row(input bit gap);
    longint sum = 0;
    longint m, d;
    longint lim = longint'(1) << (N - 1);
    exp_t e;
    for (int i = 0; i < SB; i++) sum += row_buf[i];
    m = sum / SB;
    if ((sum % SB) != 0 && sum < 0) m = m - 1;
    mean_q.push_back(m[N-1:0]);
    for (int i = 0; i < SB; i++) begin
      d = row_buf[i] - m;
`ifdef CENTER_STREAM_SAT_EN
      if (d > lim - 1) d = lim - 1;
      if (d < -lim) d = -lim;
`else
      if (lim == 0) d = 0;
`endif
      e.data = d[N-1:0];
      e.last = (i == SB - 1);
      e.row  = exp_row[RW-1:0];
      exp_q.push_back(e);
    end
    exp_row = (exp_row + 1) % SA;
    for (int i = 0; i < SB; i++) begin
      send(row_buf[i][N-1:0]);
      if (gap && $urandom_range(0, 3) == 0) begin
        ifc.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
  endtask

  task automatic fill_random(input bit full);
    logic signed [N-1:0] r;
    for (int i = 0; i < SB; i++) begin
      if (full) begin
        r = N'($urandom);
        row_buf[i] = r;
      end else begin
        row_buf[i] = longint'($urandom_range(0, 200)) - 100;
      end
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || mean_q.size() != 0) && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) check("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},   ifc.in_ready,   0);
    check({tag, "_out_valid"},  ifc.out_valid,  0);
    check({tag, "_out_data"},   ifc.out_data,   0);
    check({tag, "_out_last"},   ifc.out_last,   0);
    check({tag, "_out_row"},    ifc.out_row,    0);
    check({tag, "_mean"},       ifc.mean,       0);
    check({tag, "_mean_valid"}, ifc.mean_valid, 0);
    check({tag, "_frame_done"}, ifc.frame_done, 0);
  endtask

  // Ready driver: sole writer of out_ready, updated on falling edges.
  initial begin
    bit prev;
    int seen, hold;
    prev = 1'b0; seen = 0; hold = 0;
    ifc.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || mode != 2) begin
        seen = 0;
        hold = 0;
      end else if (prev) begin
        seen++;
      end
      case (mode)
        0: ifc.out_ready = 1'b1;
        1: ifc.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (ifc.out_valid && seen == 2 && hold < 5) begin
            ifc.out_ready = 1'b0;
            hold++;
          end else begin
            ifc.out_ready = 1'b1;
          end
        end
      endcase
      prev = ifc.out_valid && ifc.out_ready;
    end
  end

  // Monitor: scoreboard pops, hold-stability, mean/frame pulse timing.
  initial begin
    exp_t e;
    logic [N-1:0] m;
    bit fd_pend, mv_pend, stall_v, have_prev;
    logic [N-1:0] sv_data;
    logic sv_last;
    logic [RW-1:0] sv_row;
    int cyc, last_mv;
    fd_pend = 0; mv_pend = 0; stall_v = 0; have_prev = 0;
    sv_data = '0; sv_last = 0; sv_row = '0; cyc = 0; last_mv = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        fd_pend = 0; mv_pend = 0; stall_v = 0; have_prev = 0;
      end else begin
        if (fd_pend || ifc.frame_done) check("frame_done", ifc.frame_done, fd_pend);
        fd_pend = 0;
        if (mv_pend) check("first_out_valid", ifc.out_valid, 1);
        mv_pend = 0;
        if (ifc.mean_valid) begin
          if (mean_q.size() == 0) begin
            check("unexpected_mean_valid", 1, 0);
          end else begin
            m = mean_q.pop_front();
            check("mean", $signed(ifc.mean), $signed(m));
          end
          check("mean_phase_valid_ready", {ifc.out_valid, ifc.in_ready}, 0);
          if (period_chk && have_prev) check("row_period", cyc - last_mv, 2 * SB + 1);
          have_prev = period_chk;
          last_mv = cyc;
          mv_pend = 1;
        end
        if (stall_v && ifc.out_valid)
          check("stall_hold", {ifc.out_data, ifc.out_last, ifc.out_row, ifc.in_ready},
                {sv_data, sv_last, sv_row, 1'b0});
        if (ifc.out_valid && ifc.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_data", $signed(ifc.out_data), $signed(e.data));
            check("out_last_row", {ifc.out_last, ifc.out_row}, {e.last, e.row});
            if (e.last && e.row == RW'(SA - 1)) fd_pend = 1;
          end
          xfer_cnt++;
        end
        stall_v = ifc.out_valid && !ifc.out_ready;
        sv_data = ifc.out_data;
        sv_last = ifc.out_last;
        sv_row  = ifc.out_row;
      end
    end
  end

  // Stimulus.
  initial begin
    int base, g;
    ifc.in_data  = '0;
    ifc.in_valid = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", ifc.in_ready, 0);
    @(posedge clk);
    #1 check("in_ready_after_edge", ifc.in_ready, 1);
    @(negedge clk);

    // Full frame, ready and valid held high: basic, floor, overflow, random.
    mode = 0;
    period_chk = 1'b1;
    for (int i = 0; i < SB; i++) row_buf[i] = i + 1;
    run_row(0);
    for (int i = 0; i < SB; i++) row_buf[i] = (i == 0) ? -1 : 0;
    run_row(0);
    for (int i = 0; i < SB; i++) row_buf[i] = (i == SB - 1) ? 2097151 : -2097152;
    run_row(0);
    for (int r = 3; r < SA; r++) begin
      fill_random(r[0]);
      run_row(0);
    end
    ifc.in_valid = 1'b0;
    wait_drain();
    period_chk = 1'b0;

    // Stall on the third output for five cycles.
    mode = 2;
    fill_random(0);
    run_row(0);
    ifc.in_valid = 1'b0;
    wait_drain();

    // Random backpressure and input gaps.
    mode = 1;
    for (int r = 0; r < 12; r++) begin
      fill_random(r[0]);
      run_row(1);
    end
    ifc.in_valid = 1'b0;
    wait_drain();

    // Reset while the fourth output of a row is presented.
    mode = 0;
    base = xfer_cnt;
    fill_random(1);
    run_row(0);
    ifc.in_valid = 1'b0;
    g = 0;
    while (xfer_cnt < base + 3 && g < 500) begin
      @(negedge clk);
      #2;
      g++;
    end
    if (g >= 500) check("reset_wait_timeout", 1, 0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_all_zero("mid_emit_reset");
    exp_q.delete();
    mean_q.delete();
    exp_row = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_after_release", ifc.in_ready, 0);
    @(negedge clk);
    for (int i = 0; i < SB; i++) row_buf[i] = 10;
    run_row(0);
    mode = 1;
    for (int r = 0; r < 3; r++) begin
      fill_random(1);
      run_row(1);
    end
    ifc.in_valid = 1'b0;
    wait_drain();
    check("leftover_outputs", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/center_stream.md
# center_stream

Streaming mean-removal stage for the fetal ECG preprocessing chain, placed ahead of whitening/PCA. It accepts a SIZE_A × SIZE_B signed sample matrix one sample per handshake, row-major (one row = one channel's window), and accumulates each row's sum while buffering the row. It then emits every sample minus that row's mean. This parametrised, clocked, back-pressurable version adds per-row mean reporting, frame tracking and optional saturation.

## Interface
- SIZE_A, 8, rows (channels) per frame; ≥1
- SIZE_B, 8, samples per row; power of two, ≥2
- N_BITS, 22, signed two's-complement sample width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_data  in  N_BITS  signed input sample
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a sample
- out_data  out  N_BITS  centred sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_last  out  1  out_data is last sample of its row
- out_row  out  $clog2(SIZE_A) (min 1)  row index of out_data
- mean  out  N_BITS  mean of the current row, held until next update
- mean_valid  out  1  one-cycle pulse when mean updates
- frame_done  out  1  one-cycle pulse after the last sample of row SIZE_A-1 is handed off

## Operation
- States: ACCUM, MEAN, EMIT. Reset state: ACCUM.
- ACCUM: in_ready=1. Each in_valid&in_ready writes the sample to row buffer[col] and adds it, sign-extended, to the accumulator; col increments. Accepting col=SIZE_B-1 → MEAN.
- MEAN: in_ready=0. mean ← acc >>> log2(SIZE_B) (arithmetic shift, floor rounding); mean_valid pulses; acc ← 0; col ← 0; → EMIT.
- EMIT: in_ready=0; out_valid=1. out_data = buffer[col] − mean. A transfer is out_valid&out_ready; each transfer increments col.
- Transfer at col=SIZE_B-1 (out_last=1): row increments. If row was SIZE_A-1, row wraps to 0 and frame_done pulses the next cycle. In both cases → ACCUM.
- Accumulator width is N_BITS+log2(SIZE_B), so it cannot overflow. Subtraction is done at N_BITS+1 bits and then reduced per Configuration.
- out_data, out_last and out_row stay stable while out_valid=1 and out_ready=0.
- Reset values: in_ready=0 while rst_n low and 1 from the first clock edge after release. All other outputs are 0. acc, col and row are 0.
- Reset asserted mid-row or mid-EMIT discards the partial row and any pending outputs. No frame_done is issued for the aborted frame.

## Timing
- Input acceptance at cycle T of col SIZE_B-1 → MEAN at T+1 (mean_valid high at T+1) → first out_valid at T+2.
- Best-case row period with out_ready held at 1: SIZE_B (ACCUM) + 1 (MEAN) + SIZE_B (EMIT) cycles.
- in_valid during MEAN/EMIT is ignored (in_ready=0). The source holds the data.
- frame_done is high in the cycle after the final transfer, concurrent with ACCUM of row 0.

## Configuration
- CENTER_STREAM_SAT_EN defined: the N_BITS+1 difference clamps to [−2^(N_BITS−1), 2^(N_BITS−1)−1].
- CENTER_STREAM_SAT_EN undefined: the difference is truncated to the low N_BITS bits (two's-complement wrap).

## Test plan
- Basic row, SIZE_B=8, N_BITS=22: inputs 1..8 → mean=4, mean_valid pulse; out_data −3,−2,−1,0,1,2,3,4; out_last only on the 4.
- Floor rounding: row −1,0,0,0,0,0,0,0 → mean=−1; out_data 0,1,1,1,1,1,1,1.
- Overflow: seven −2097152 then one 2097151 → mean=−1572865. Last output is 2097151 with SAT_EN and −524288 without. The first seven outputs are −524287 in both builds (no clamp needed).
- Backpressure: drop out_ready for 5 cycles on the 3rd output → out_data/out_row/out_last unchanged; no outputs lost or duplicated; in_ready stays 0.
- Frame: SIZE_A=8 rows streamed with in_valid and out_ready held at 1 → out_row 0..7; frame_done pulses once, the cycle after row 7's out_last transfer; row period is 17 cycles.
- Reset mid-EMIT at the 4th output → all outputs 0 immediately. The next row after release (inputs 10 ×8) gives mean=10, outputs all 0, out_row=0.
